// File: rtl/cp0_timer_unit.sv
// Purpose : CP0 timer / interrupt / TLB-index block: Count with prescaler, Compare with
//           sticky timer interrupt, Random/Wired TLB index pair, synchronised interrupt request.
// Latency : register writes take effect next cycle; reads are combinational; hardware_int to
//           int_req is SYNC_STAGES+1 cycles.
// Backpressure: none. Writes are single-cycle strobes and are always accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   we, wr_addr, wr_sel, data_i   CP0 write port (WB stage)
//   rd_addr, rd_sel, data_o       CP0 read port (combinational, 0 while in reset)
//   hardware_int               asynchronous external interrupt lines
//   sw_int, im, ie, exl, erl   Cause/Status fields feeding the interrupt request
//   timer_int, ip, int_req     timer interrupt, pending vector, registered request
//   random_idx, wired          current Random and Wired TLB indices
module cp0_timer_unit #(
    parameter int TLB_ENTRIES = 16,
    parameter int COUNT_DIV   = 1,
    parameter int NUM_HW_INT  = 6,
    parameter int TIMER_IP    = 7,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [4:0]            wr_addr,
    input  logic [2:0]            wr_sel,
    input  logic [31:0]           data_i,
    input  logic [4:0]            rd_addr,
    input  logic [2:0]            rd_sel,
    output logic [31:0]           data_o,
    input  logic [NUM_HW_INT-1:0] hardware_int,
    input  logic [1:0]            sw_int,
    input  logic [7:0]            im,
    input  logic                  ie,
    input  logic                  exl,
    input  logic                  erl,
    output logic                  timer_int,
    output logic [7:0]            ip,
    output logic                  int_req,
    output logic [IDX_W-1:0]      random_idx,
    output logic [IDX_W-1:0]      wired
);

    localparam logic [4:0] ADDR_RANDOM  = 5'd1;
    localparam logic [4:0] ADDR_WIRED   = 5'd6;
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;

    localparam logic [IDX_W-1:0] RAND_TOP   = IDX_W'(TLB_ENTRIES - 1);
    // An 8-bit prescaler covers the full 1..256 divide range.
    localparam logic [7:0]       PRESC_LAST = 8'(COUNT_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]            presc_q,   presc_d;
    logic [31:0]           count_q,   count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  timer_q,   timer_d;
    logic [IDX_W-1:0]      random_q,  random_d;
    logic [IDX_W-1:0]      wired_q,   wired_d;
    logic                  int_req_q, int_req_d;
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];

    // ------------------------------------------------------------------
    // Write decode: only select 0 of the four owned registers is writable.
    // ------------------------------------------------------------------
    logic wr_sel0;
    logic wr_count;
    logic wr_compare;
    logic wr_wired;

    assign wr_sel0    = we && (wr_sel == 3'd0);
    assign wr_count   = wr_sel0 && (wr_addr == ADDR_COUNT);
    assign wr_compare = wr_sel0 && (wr_addr == ADDR_COMPARE);
    assign wr_wired   = wr_sel0 && (wr_addr == ADDR_WIRED);

    // ------------------------------------------------------------------
    // Count and prescaler
    // ------------------------------------------------------------------
    logic tick;

    // With COUNT_DIV=1 the prescaler sits at 0 == PRESC_LAST, so tick is constant.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? 8'd0 : presc_q + 8'd1;
        count_d = tick ? count_q + 32'd1 : count_q;
        // A software write restarts the tick phase so the new value lasts a full period.
        if (wr_count) begin
            count_d = data_i;
            presc_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Compare and sticky timer interrupt
    // ------------------------------------------------------------------
    logic match;

    assign match = (count_q == compare_q);

    always_comb begin
        compare_d = compare_q;
        timer_d   = timer_q | match;
        // Writing Compare acknowledges the interrupt, even if the old value matches now.
        if (wr_compare) begin
            compare_d = data_i;
            timer_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Random / Wired
    // ------------------------------------------------------------------
    always_comb begin
        wired_d = wired_q;
        if ((random_q == wired_q) || (random_q == '0) || (wired_q >= RAND_TOP)) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - 1'b1;
        end
        if (wr_wired) begin
            wired_d  = data_i[IDX_W-1:0];
            random_d = RAND_TOP;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pending vector and request
    // ------------------------------------------------------------------
    logic [NUM_HW_INT-1:0] hw_s;
    logic [7:0]            ip_vec;

    assign hw_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        ip_vec      = 8'b0;
        ip_vec[1:0] = sw_int;
        for (int i = 0; i < NUM_HW_INT; i++) begin
            ip_vec[2+i] = hw_s[i];
        end
        ip_vec[TIMER_IP] = ip_vec[TIMER_IP] | timer_q;
    end

    assign int_req_d = (|(ip_vec & im)) & ie & ~exl & ~erl;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= 8'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            timer_q   <= 1'b0;
            random_q  <= RAND_TOP;
            wired_q   <= '0;
            int_req_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
            random_q  <= random_d;
            wired_q   <= wired_d;
            int_req_q <= int_req_d;
        end
    end

    // Synchroniser chain for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= hardware_int;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (zero-extended); forced to 0 while reset is held.
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        if (rd_sel == 3'd0) begin
            case (rd_addr)
                ADDR_RANDOM:  rd_data = 32'(random_q);
                ADDR_WIRED:   rd_data = 32'(wired_q);
                ADDR_COUNT:   rd_data = count_q;
                ADDR_COMPARE: rd_data = compare_q;
                default:      rd_data = 32'd0;
            endcase
        end
    end

    assign data_o     = rst_n ? rd_data : 32'd0;
    assign timer_int  = timer_q;
    assign ip         = ip_vec;
    assign int_req    = int_req_q;
    assign random_idx = random_q;
    assign wired      = wired_q;

endmodule

// File: doc/cp0_timer_unit.md
Name: cp0_timer_unit

Overview:
- Parametrised timer/interrupt/TLB-index block for the CP0 register file.
- Holds Count with a programmable prescaler and Compare with a sticky timer interrupt.
- Holds the Random/Wired TLB-index pair, sized by TLB depth.
- Synchronises hardware interrupt lines and produces a registered, masked interrupt request for the exception unit; CP0 forwards mtc0/mfc0 accesses for Count, Compare, Random and Wired to this block.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; IDX_W = $clog2(TLB_ENTRIES), must be ≥2.
- COUNT_DIV, 1, Count increments once every COUNT_DIV clk cycles (1..256).
- NUM_HW_INT, 6, external interrupt lines mapped to IP[2+NUM_HW_INT-1:2] (1..6).
- TIMER_IP, 7, IP bit onto which timer_int is ORed (2..7).
- SYNC_STAGES, 2, synchroniser flops on hardware_int (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  CP0 write strobe (WB stage)
- wr_addr  in  5  write register number
- wr_sel  in  3  write select
- data_i  in  32  write data
- rd_addr  in  5  read register number
- rd_sel  in  3  read select
- data_o  out  32  read data, combinational
- hardware_int  in  NUM_HW_INT  asynchronous interrupt lines
- sw_int  in  2  Cause[9:8] software interrupts
- im  in  8  Status[15:8]
- ie  in  1  Status[0]
- exl  in  1  Status[1]
- erl  in  1  Status[2]
- timer_int  out  1  sticky Compare match
- ip  out  8  pending vector for Cause[15:8]
- int_req  out  1  registered interrupt request to exception unit
- random_idx  out  IDX_W  current Random for TLBWR
- wired  out  IDX_W  current Wired

Behaviour:
- Reset values:
  - Count = 0, prescaler = 0, Compare = 32'hFFFF_FFFF.
  - timer_int = 0, Wired = 0, Random = TLB_ENTRIES-1.
  - Sync flops = 0, int_req = 0, data_o = 0 while rst_n low.
- Register map, {addr,sel}:
  - Random = {1,0}, read-only; writes ignored.
  - Wired = {6,0}, data_i[IDX_W-1:0].
  - Count = {9,0}.
  - Compare = {11,0}.
  - All other addresses read 0; writes to them ignored.
  - Reads zero-extend to 32 bits.
- Prescaler:
  - Counts 0..COUNT_DIV-1, wraps to 0.
  - tick asserts in the cycle the prescaler equals COUNT_DIV-1; Count <= Count+1 on tick, wrapping FFFF_FFFF→0.
  - COUNT_DIV=1 means tick every cycle.
- Count write: Count <= data_i and prescaler <= 0; the write wins over a simultaneous tick.
- Compare:
  - match = (Count == Compare), evaluated on the registered values every cycle.
  - timer_int <= 1 when match is true; it stays set (sticky).
  - Compare write: Compare <= data_i, timer_int <= 0. The write wins over a same-cycle match; a match on the new value sets timer_int from the next cycle onward.
- Random, every cycle:
  - If Random == Wired, or Random == 0, then Random <= TLB_ENTRIES-1; else Random <= Random-1.
  - Wired write: Wired <= data_i[IDX_W-1:0] and Random <= TLB_ENTRIES-1.
  - If Wired ≥ TLB_ENTRIES-1, Random holds at TLB_ENTRIES-1.
- Interrupt path:
  - hardware_int passes through SYNC_STAGES flops to give hw_s.
  - ip = {hw_s placed at bits 2.., unused bits 0} | (timer_int << TIMER_IP) | {6'b0, sw_int}; combinational from registered state.
  - int_req <= (|(ip & im)) & ie & ~exl & ~erl, one-cycle registered.
  - Latency from a hardware_int edge to int_req is SYNC_STAGES+1 cycles.
- Reset asserted mid-operation returns everything to reset values immediately; no partial prescaler state is retained.

Test Plan:
1. COUNT_DIV=4, reset release, no writes → Count reads 0,0,0,0,1 over cycles 1..5; Count=3 at cycle 13.
2. Write Compare=5, COUNT_DIV=1 → timer_int rises the cycle after Count==5. It stays 1 after Count=6. A Compare write of 20 clears it the next cycle. A same-cycle match and write leaves it 0.
3. TLB_ENTRIES=16, Wired=0 → Random sequence 15,14..0,15.
4. TLB_ENTRIES=16, write Wired=12 → Random =15 next cycle, then 14,13,12,15.
5. TLB_ENTRIES=16, write Wired=15 → Random holds at 15.
6. Interrupt masking and latency:
   - SYNC_STAGES=2, ie=1, exl=0, erl=0, im=8'h04: pulse hardware_int[0] high → ip[2]=1 after 2 cycles, int_req=1 after 3 cycles.
   - Same stimulus with exl=1 → int_req stays 0.
   - With im=8'h80 and timer_int set → int_req=1.
7. Mid-count reset: assert rst_n low with Count=0x1234 and timer_int=1 → all outputs return to reset values at once; after release Count restarts from 0 and the prescaler restarts from 0.
